cordic_datapath: RTL and testbench

//  Iterative CORDIC datapath driven by the cordicctrl FSM (ld/init/fin). Holds x/y/z working

---
 rtl/cordic_if.sv | 37 +++
 rtl/cordic_datapath.sv | 95 +++++++++
 tb/tb_cordic_datapath.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_if.sv
// Controller <-> CORDIC datapath bundle. The mode signal exists only when
// CORDIC_VECTORING_EN is defined.
interface cordic_if #(
    parameter int W     = 16,
    parameter int CNT_W = 4
);
    logic                init;
    logic                ld;
    logic                fin;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic signed [W-1:0] z_in;
`ifdef CORDIC_VECTORING_EN
    logic                mode;
`endif
    logic [CNT_W-1:0]    itr;
    logic signed [W-1:0] x_out;
    logic signed [W-1:0] y_out;
    logic signed [W-1:0] z_out;
    logic                done;

    modport master (
`ifdef CORDIC_VECTORING_EN
        output mode,
`endif
        output init, ld, fin, x_in, y_in, z_in,
        input  itr, x_out, y_out, z_out, done
    );

    modport slave (
`ifdef CORDIC_VECTORING_EN
        input  mode,
`endif
        input  init, ld, fin, x_in, y_in, z_in,
        output itr, x_out, y_out, z_out, done
    );
endinterface

// File: rtl/cordic_datapath.sv
// Iterative CORDIC datapath: one shift-add micro-rotation per ld, result latched on fin.
// Define CORDIC_VECTORING_EN to add the rotation/vectoring mode input.
module cordic_datapath #(
    parameter int W     = 16,
    parameter int ITERS = 16,
    parameter int CNT_W = 4
) (
    input  logic     clk,
    input  logic     rst_b,
    cordic_if.slave  bus
);
    // arctan(2^-i) in Q2.13, rounded to nearest
    localparam logic signed [W-1:0] ATAN [ITERS] = '{
        16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019, 16'sd511, 16'sd256, 16'sd128, 16'sd64,
        16'sd32,   16'sd16,   16'sd8,    16'sd4,    16'sd2,   16'sd1,   16'sd0,   16'sd0
    };

    logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [W-1:0] x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
    logic [CNT_W-1:0]    itr_q, itr_d;
    logic                done_q, done_d;
    logic signed [W-1:0] x_sh, y_sh;
    logic                d_pos;

    always_comb begin
        x_sh = x_q >>> itr_q;
        y_sh = y_q >>> itr_q;
`ifdef CORDIC_VECTORING_EN
        // vectoring steers y toward zero, rotation steers z toward zero
        d_pos = bus.mode ? y_q[W-1] : ~z_q[W-1];
`else
        d_pos = ~z_q[W-1];
`endif
        x_d   = x_q;
        y_d   = y_q;
        z_d   = z_q;
        itr_d = itr_q;
        if (bus.init) begin
            x_d   = bus.x_in;
            y_d   = bus.y_in;
            z_d   = bus.z_in;
            itr_d = '0;
        end else if (bus.ld) begin
            if (d_pos) begin
                x_d = x_q - y_sh;
                y_d = y_q + x_sh;
                z_d = z_q - ATAN[itr_q];
            end else begin
                x_d = x_q + y_sh;
                y_d = y_q - x_sh;
                z_d = z_q + ATAN[itr_q];
            end
            itr_d = itr_q + CNT_W'(1);
        end

        // fin samples the pre-update working registers
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        z_out_d = z_out_q;
        if (bus.fin) begin
            x_out_d = x_q;
            y_out_d = y_q;
            z_out_d = z_q;
        end
        done_d = bus.fin;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            itr_q   <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
            done_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            itr_q   <= itr_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            z_out_q <= z_out_d;
            done_q  <= done_d;
        end
    end

    assign bus.itr   = itr_q;
    assign bus.x_out = x_out_q;
    assign bus.y_out = y_out_q;
    assign bus.z_out = z_out_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_cordic_datapath.sv
// Bench for cordic_datapath: acts as the controller, checks against an integer CORDIC
// model and against analytic cos/sin/atan values within tolerance.
module tb_cordic_datapath;
    logic clk;
    logic rst_b;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   last_x;

    cordic_if #(.W(16), .CNT_W(4)) bus();

    cordic_datapath #(.W(16), .ITERS(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    localparam int ATAN_TAB [16] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64,
                                     32, 16, 8, 4, 2, 1, 0, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
        int diff;
        n_checks++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Reference: n micro-rotations on 16-bit wrapping integers.
    function automatic void model(input int xi, input int yi, input int zi, input int n,
                                  input bit vec, output int xo, output int yo, output int zo);
        shortint x, y, z, xs, ys;
        x = shortint'(xi);
        y = shortint'(yi);
        z = shortint'(zi);
        for (int i = 0; i < n; i++) begin
            int s;
            bit pos;
            s   = i % 16;
            xs  = x >>> s;
            ys  = y >>> s;
            pos = vec ? (y < 0) : (z >= 0);
            if (pos) begin
                x = shortint'(x - ys);
                y = shortint'(y + xs);
                z = shortint'(z - ATAN_TAB[s]);
            end else begin
                x = shortint'(x + ys);
                y = shortint'(y - xs);
                z = shortint'(z + ATAN_TAB[s]);
            end
        end
        xo = x;
        yo = y;
        zo = z;
    endfunction

    task automatic set_mode(input bit m);
`ifdef CORDIC_VECTORING_EN
        bus.mode = m;
`else
        if (m) $display("note: vectoring requested but not built in");
`endif
    endtask

    // Full controller sequence; optional idle cycles between ld pulses.
    task automatic run_op(input int xi, input int yi, input int zi, input bit m,
                          input bit gaps, output int xo, output int yo, output int zo);
        int t0, ex, ey, ez;
        @(negedge clk);
        bus.init = 1'b1;
        bus.ld   = 1'b1;
        bus.x_in = 16'(xi);
        bus.y_in = 16'(yi);
        bus.z_in = 16'(zi);
        set_mode(m);
        t0 = cyc;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus.init = 1'b0;
            bus.ld   = 1'b0;
            chk("itr_step", int'(bus.itr), k);
            if (gaps && $urandom_range(1) == 1) begin
                @(negedge clk);
                chk("itr_hold", int'(bus.itr), k);
            end
            bus.ld = 1'b1;
        end
        @(negedge clk);
        bus.ld = 1'b0;
        chk("itr_wrap", int'(bus.itr), 0);
        chk("done_early", int'(bus.done), 0);
        chk("x_out_hold", int'(bus.x_out), last_x);
        bus.fin = 1'b1;
        @(negedge clk);
        bus.fin = 1'b0;
        chk("done_pulse", int'(bus.done), 1);
        if (!gaps) chk("latency", cyc - t0, 18);
        model(xi, yi, zi, 16, m, ex, ey, ez);
        xo = int'(bus.x_out);
        yo = int'(bus.y_out);
        zo = int'(bus.z_out);
        chk("x_model", xo, ex);
        chk("y_model", yo, ey);
        chk("z_model", zo, ez);
        last_x = xo;
        @(negedge clk);
        chk("done_clear", int'(bus.done), 0);
    endtask

    initial begin
        int xo, yo, zo, ex, ey, ez;
        int xi, yi, zi;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        last_x   = 0;
        bus.init = 1'b0;
        bus.ld   = 1'b0;
        bus.fin  = 1'b0;
        bus.x_in = '0;
        bus.y_in = '0;
        bus.z_in = '0;
        set_mode(1'b0);
        rst_b = 1'b0;
        #12;
        chk("rst_itr", int'(bus.itr), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_x_out", int'(bus.x_out), 0);
        @(negedge clk);
        rst_b = 1'b1;

        // cos/sin of 0
        run_op(4975, 0, 0, 1'b0, 1'b0, xo, yo, zo);
        chk("cos0", xo, 8192, 4);
        chk("sin0", yo, 0, 4);
        chk("z0", zo, 0, 2);

        // pi/4
        run_op(4975, 0, 6434, 1'b0, 1'b0, xo, yo, zo);
        chk("cos_pi4", xo, 5793, 8);
        chk("sin_pi4", yo, 5793, 8);
        chk("z_pi4", zo, 0, 2);

        // -pi/3
        run_op(4975, 0, -8579, 1'b0, 1'b0, xo, yo, zo);
        chk("cos_m_pi3", xo, 4096, 8);
        chk("sin_m_pi3", yo, -7094, 8);

        // random rotations against the model and analytic values
        for (int t = 0; t < 12; t++) begin
            real ang;
            zi  = int'($urandom_range(25736)) - 12868;
            xi  = 4975;
            ang = real'(zi) / 8192.0;
            run_op(xi, 0, zi, 1'b0, t[0], xo, yo, zo);
            chk("rand_cos", xo, int'($cos(ang) * 8192.0), 10);
            chk("rand_sin", yo, int'($sin(ang) * 8192.0), 10);
        end
        for (int t = 0; t < 8; t++) begin
            xi = int'($urandom_range(19660)) - 9830;
            yi = int'($urandom_range(19660)) - 9830;
            zi = int'($urandom_range(25736)) - 12868;
            run_op(xi, yi, zi, 1'b0, 1'b1, xo, yo, zo);
        end

        // priority: init over ld, then fin together with ld
        @(negedge clk);
        bus.init = 1'b1;
        bus.ld   = 1'b1;
        bus.x_in = 16'sd1000;
        bus.y_in = -16'sd2000;
        bus.z_in = 16'sd3000;
        @(negedge clk);
        bus.init = 1'b0;
        bus.ld   = 1'b0;
        chk("prio_itr", int'(bus.itr), 0);
        bus.fin = 1'b1;
        @(negedge clk);
        bus.fin = 1'b0;
        chk("prio_x", int'(bus.x_out), 1000);
        chk("prio_y", int'(bus.y_out), -2000);
        chk("prio_z", int'(bus.z_out), 3000);
        bus.ld = 1'b1;
        repeat (3) @(negedge clk);
        bus.fin = 1'b1;
        @(negedge clk);
        bus.ld  = 1'b0;
        bus.fin = 1'b0;
        model(1000, -2000, 3000, 3, 1'b0, ex, ey, ez);
        chk("finld_x", int'(bus.x_out), ex);
        chk("finld_y", int'(bus.y_out), ey);
        chk("finld_z", int'(bus.z_out), ez);
        chk("finld_itr", int'(bus.itr), 4);
        chk("finld_done", int'(bus.done), 1);
        last_x = ex;

`ifdef CORDIC_VECTORING_EN
        run_op(4096, 4096, 0, 1'b1, 1'b0, xo, yo, zo);
        chk("vec_mag", xo, 9540, 8);
        chk("vec_y", yo, 0, 4);
        chk("vec_ang", zo, 6434, 4);
        for (int t = 0; t < 6; t++) begin
            xi = int'($urandom_range(6000)) + 500;
            yi = int'($urandom_range(12000)) - 6000;
            run_op(xi, yi, 0, 1'b1, t[0], xo, yo, zo);
            chk("vec_rand_ang", zo, int'($atan2(real'(yi), real'(xi)) * 8192.0), 8);
        end
        set_mode(1'b0);
`endif

        // asynchronous reset mid-run at itr=7
        @(negedge clk);
        bus.init = 1'b1;
        bus.ld   = 1'b1;
        bus.x_in = 16'sd4975;
        bus.y_in = 16'sd0;
        bus.z_in = 16'sd2000;
        @(negedge clk);
        bus.init = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_itr", int'(bus.itr), 7);
        #2;
        rst_b = 1'b0;
        #1;
        chk("arst_itr", int'(bus.itr), 0);
        chk("arst_x_out", int'(bus.x_out), 0);
        chk("arst_y_out", int'(bus.y_out), 0);
        chk("arst_z_out", int'(bus.z_out), 0);
        chk("arst_done", int'(bus.done), 0);
        @(negedge clk);
        bus.ld = 1'b0;
        chk("arst_no_done", int'(bus.done), 0);
        rst_b  = 1'b1;
        @(negedge clk);
        bus.fin = 1'b1;
        @(negedge clk);
        bus.fin = 1'b0;
        chk("arst_x_clr", int'(bus.x_out), 0);
        chk("arst_z_clr", int'(bus.z_out), 0);
        chk("arst_fin_done", int'(bus.done), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
